// File: rtl/soul_mover.sv
// soul_mover: moves the player soul inside the battle box.
// Direction codes (0-3) are one-cycle move requests that walk STEP pixels,
// one pixel per frame tick. Colour codes (4-7) set the soul colour.
// One move runs at a time, and one further request can wait in a pending slot.
module soul_mover #(
  parameter int W      = 10,
  parameter int X_MIN  = 200,
  parameter int X_MAX  = 440,
  parameter int Y_MIN  = 240,
  parameter int Y_MAX  = 400,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 320,
  parameter int STEP   = 8
) (
  input  logic         Pclk,
  input  logic         RESET,
  input  logic [2:0]   cmd,
  input  logic         tick,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [2:0]   color,
  output logic         moving,
  output logic         dropped
);

  // FSM encoding
  localparam logic IDLE = 1'b0;
  localparam logic MOVE = 1'b1;

  // Direction encoding, identical to the low two bits of cmd
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bounds, reset values and step length at their register widths
  localparam logic [W-1:0] X_LO    = W'(X_MIN);
  localparam logic [W-1:0] X_HI    = W'(X_MAX);
  localparam logic [W-1:0] Y_LO    = W'(Y_MIN);
  localparam logic [W-1:0] Y_HI    = W'(Y_MAX);
  localparam logic [W-1:0] X_RST   = W'(X_INIT);
  localparam logic [W-1:0] Y_RST   = W'(Y_INIT);
  localparam logic [W-1:0] ONE_PX  = W'(1);
  localparam logic [7:0]   STEP_L  = 8'(STEP);
  localparam logic [2:0]   COL_RST = 3'd4;

  logic       state;
  logic [1:0] dir;        // direction of the move in progress
  logic [7:0] remaining;  // pixels still to go in the current move
  logic       slot_full;  // one request waiting behind the current move
  logic [1:0] slot_dir;

  logic req;        // this cycle's cmd is a move request
  logic at_bound;   // one more pixel in dir would leave the box
  logic last_px;    // this tick consumes the final pixel of the move
  logic move_end;   // the current move finishes in this cycle
  logic step_px;    // position register advances on this clock edge

  assign req    = ~cmd[2];
  assign moving = (state == MOVE);

  // Bound detection: compare before stepping so unsigned arithmetic never wraps.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    at_bound = 1'b0;
    case (dir)
      DIR_UP:    at_bound = (pos_y <= Y_LO);
      DIR_DOWN:  at_bound = (pos_y >= Y_HI);
      DIR_LEFT:  at_bound = (pos_x <= X_LO);
      DIR_RIGHT: at_bound = (pos_x >= X_HI);
      default:   at_bound = 1'b0;
    endcase
  end

  // Move termination and pixel stepping decisions for this cycle
  always_comb begin
    last_px  = (remaining <= 8'd1);
    move_end = (state == MOVE) && tick && (at_bound || last_px);
    step_px  = (state == MOVE) && tick && !at_bound;
  end

  // Colour register: loaded by colour codes only, held on direction codes.
  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      color <= COL_RST;
    end else if (cmd[2]) begin
      color <= cmd;
    end
  end

  // Position registers: one pixel per tick in the active direction, clamped to the box
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      pos_x <= X_RST;
      pos_y <= Y_RST;
    end else if (step_px) begin
      case (dir)
        DIR_UP:    pos_y <= pos_y - ONE_PX;
        DIR_DOWN:  pos_y <= pos_y + ONE_PX;
        DIR_LEFT:  pos_x <= pos_x - ONE_PX;
        DIR_RIGHT: pos_x <= pos_x + ONE_PX;
        default: ;
      endcase
    end
  end

  // Move FSM: start moves, count pixels, chain into the pending or simultaneous request
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Ticks are ignored here, even in the same cycle as a request.
          if (req) begin
            dir       <= cmd[1:0];
            remaining <= STEP_L;
            state     <= MOVE;
          end
        end
        MOVE: begin
          if (move_end) begin
            if (slot_full) begin
              // Waiting request goes first; a simultaneous one refills the slot.
              dir       <= slot_dir;
              remaining <= STEP_L;
            end else if (req) begin
              // Empty slot: the simultaneous request starts immediately.
              dir       <= cmd[1:0];
              remaining <= STEP_L;
            end else begin
              state     <= IDLE;
              remaining <= '0;
            end
          end else if (tick) begin
            remaining <= remaining - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

  // Pending slot: holds at most one request queued behind the active move
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      slot_full <= 1'b0;
      slot_dir  <= DIR_UP;
    end else if (state == MOVE) begin
      if (move_end) begin
        // Slot contents start now; it stays full only if a new request arrives.
        if (slot_full) begin
          slot_full <= req;
          if (req) begin
            slot_dir <= cmd[1:0];
          end
        end
      end else if (req && !slot_full) begin
        slot_full <= 1'b1;
        slot_dir  <= cmd[1:0];
      end
    end
  end

  // Drop pulse: a request mid-move with the slot already occupied is discarded
  always_ff @(posedge Pclk) begin
    if (RESET) begin
      dropped <= 1'b0;
    end else begin
      dropped <= (state == MOVE) && !move_end && req && slot_full;
    end
  end

endmodule

// File: tb/tb_soul_mover.sv
// tb_soul_mover: directed stimulus for two soul_mover instances (default box
// and a narrow box with X_MAX=324), checked each cycle against a behavioural
// model built on a request queue, plus hand-computed literal expectations.
module tb_soul_mover;

  logic       Pclk = 1'b0;
  logic       RESET;
  logic [2:0] cmd;
  logic       tick;

  logic [9:0] px_o  [2];
  logic [9:0] py_o  [2];
  logic [2:0] col_o [2];
  logic       mv_o  [2];
  logic       dr_o  [2];

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] idle_cmd;

  always #5 Pclk = ~Pclk;

  soul_mover dut (
    .Pclk(Pclk), .RESET(RESET), .cmd(cmd), .tick(tick),
    .pos_x(px_o[0]), .pos_y(py_o[0]), .color(col_o[0]),
    .moving(mv_o[0]), .dropped(dr_o[0])
  );

  soul_mover #(.X_MAX(324)) dut_b (
    .Pclk(Pclk), .RESET(RESET), .cmd(cmd), .tick(tick),
    .pos_x(px_o[1]), .pos_y(py_o[1]), .color(col_o[1]),
    .moving(mv_o[1]), .dropped(dr_o[1])
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as the DUT saw them on the last rising edge
  logic [2:0] s_cmd;
  logic       s_tick;
  logic       s_rst;
  always @(posedge Pclk) begin
    s_cmd  <= cmd;
    s_tick <= tick;
    s_rst  <= RESET;
  end

  // Behavioural model per instance, advanced and compared on the falling edge
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int XMAX = (g == 0) ? 440 : 324;
    int px, py, col, cur, left;
    bit active, drop, valid;
    int pend[$];

    always @(negedge Pclk) begin
      int nx, ny;
      bit req, ended;
      if (s_rst === 1'b1) begin
        px = 320; py = 320; col = 4; active = 0; left = 0; drop = 0;
        pend.delete();
        valid = 1;
      end else if (valid) begin
        req  = (s_cmd <= 3'd3);
        drop = 0;
        if (!req) col = int'(s_cmd);
        if (!active) begin
          if (req) begin
            active = 1; cur = int'(s_cmd); left = 8;
          end
        end else begin
          ended = 0;
          if (s_tick) begin
            nx = px; ny = py;
            case (cur)
              0: ny = py - 1;
              1: ny = py + 1;
              2: nx = px - 1;
              default: nx = px + 1;
            endcase
            if (nx >= 200 && nx <= XMAX && ny >= 240 && ny <= 400) begin
              px = nx; py = ny; left = left - 1;
              if (left == 0) ended = 1;
            end else begin
              left = 0; ended = 1;
            end
          end
          if (ended) begin
            if (req) pend.push_back(int'(s_cmd));
            if (pend.size() > 0) begin
              cur = pend.pop_front(); left = 8;
            end else begin
              active = 0;
            end
          end else if (req) begin
            if (pend.size() == 0) pend.push_back(int'(s_cmd));
            else drop = 1;
          end
        end
      end
      if (valid) begin
        check($sformatf("m%0d pos_x", g), int'(px_o[g]), px);
        check($sformatf("m%0d pos_y", g), int'(py_o[g]), py);
        check($sformatf("m%0d color", g), int'(col_o[g]), col);
        check($sformatf("m%0d moving", g), int'(mv_o[g]), int'(active));
        check($sformatf("m%0d dropped", g), int'(dr_o[g]), int'(drop));
      end
    end
  end

  // One clock cycle with the given inputs; returns #1 after the rising edge
  task automatic step(input logic [2:0] c, input logic t);
    cmd  = c;
    tick = t;
    @(posedge Pclk);
    #1;
    cmd  = idle_cmd;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(idle_cmd, 1'b1);
  endtask

  initial begin
    idle_cmd = 3'd4;
    cmd      = 3'd4;
    tick     = 1'b0;
    RESET    = 1'b1;

    // 1: reset state
    step(3'd4, 1'b0);
    step(3'd4, 1'b0);
    RESET = 1'b0;
    check("t1 pos_x", int'(px_o[0]), 320);
    check("t1 pos_y", int'(py_o[0]), 320);
    check("t1 color", int'(col_o[0]), 4);
    check("t1 moving", int'(mv_o[0]), 0);
    check("t1 dropped", int'(dr_o[0]), 0);

    // 2 and 4: move right; narrow instance clamps at 324
    step(3'd3, 1'b1);  // tick alongside an IDLE request is ignored
    check("t2 moving start", int'(mv_o[0]), 1);
    check("t2 x no move", int'(px_o[0]), 320);
    for (int i = 1; i <= 10; i++) begin
      step(idle_cmd, 1'b1);
      check($sformatf("t2 x tick%0d", i), int'(px_o[0]), (i < 8) ? 320 + i : 328);
      check($sformatf("t2 moving tick%0d", i), int'(mv_o[0]), (i < 8) ? 1 : 0);
      check($sformatf("t4 x tick%0d", i), int'(px_o[1]), (i < 4) ? 320 + i : 324);
      check($sformatf("t4 moving tick%0d", i), int'(mv_o[1]), (i < 5) ? 1 : 0);
      step(idle_cmd, 1'b0);
    end
    check("t2 y", int'(py_o[0]), 320);

    // 3: up, then down queued, then left dropped
    step(3'd0, 1'b0);
    step(3'd1, 1'b0);
    check("t3 no drop", int'(dr_o[0]), 0);
    step(3'd2, 1'b0);
    check("t3 drop pulse", int'(dr_o[0]), 1);
    step(idle_cmd, 1'b0);
    check("t3 drop clears", int'(dr_o[0]), 0);
    ticks(8);
    check("t3 y mid", int'(py_o[0]), 312);
    check("t3 moving mid", int'(mv_o[0]), 1);
    ticks(8);
    check("t3 y end", int'(py_o[0]), 320);
    check("t3 x end", int'(px_o[0]), 328);
    check("t3 moving end", int'(mv_o[0]), 0);

    // 5: colour codes; direction codes leave colour alone
    idle_cmd = 3'd5;
    step(3'd5, 1'b0);
    check("t5 color 5", int'(col_o[0]), 5);
    step(3'd2, 1'b0);
    check("t5 color held", int'(col_o[0]), 5);
    idle_cmd = 3'd4;
    step(3'd4, 1'b0);
    check("t5 color 4", int'(col_o[0]), 4);
    ticks(8);
    check("t5 x after left", int'(px_o[0]), 320);
    check("t5 bx after left", int'(px_o[1]), 316);

    // 6: reset mid-move aborts everything
    step(3'd1, 1'b0);
    ticks(3);
    check("t6 y before reset", int'(py_o[0]), 323);
    RESET = 1'b1;
    step(idle_cmd, 1'b0);
    RESET = 1'b0;
    check("t6 x reset", int'(px_o[0]), 320);
    check("t6 y reset", int'(py_o[0]), 320);
    check("t6 moving reset", int'(mv_o[0]), 0);
    ticks(3);
    check("t6 y still", int'(py_o[0]), 320);

    // 7: request on the ending tick with the slot full
    step(3'd3, 1'b0);
    step(3'd2, 1'b0);
    ticks(7);
    step(3'd0, 1'b1);
    check("t7 x end right", int'(px_o[0]), 328);
    check("t7 still moving", int'(mv_o[0]), 1);
    ticks(8);
    check("t7 x after left", int'(px_o[0]), 320);
    check("t7 moving up", int'(mv_o[0]), 1);
    ticks(8);
    check("t7 y after up", int'(py_o[0]), 312);
    check("t7 idle", int'(mv_o[0]), 0);

    // 8: request on the ending tick with the slot empty
    step(3'd1, 1'b0);
    ticks(7);
    step(3'd2, 1'b1);
    check("t8 y end down", int'(py_o[0]), 320);
    check("t8 still moving", int'(mv_o[0]), 1);
    ticks(8);
    check("t8 x after left", int'(px_o[0]), 312);
    check("t8 idle", int'(mv_o[0]), 0);

    step(idle_cmd, 1'b0);
    step(idle_cmd, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
